// File: rtl/rect_motion_ctrl.sv
// rect_motion_ctrl: frame-synchronous rectangle position controller with edge clamping.
// Optional boost-key path is built only when `define RECT_BOOST_EN is set.
//
// state  | meaning
// IDLE   | wait for an update tick; snapshot dir on it
// CALC_Y | compute next y into shadow register
// CALC_X | compute next x into shadow register
// COMMIT | load pos/at_edge/dir_err together, pulse strobe
module rect_motion_ctrl #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int RECT_W    = 100,
  parameter int RECT_H    = 50,
  parameter int INI_X     = 269,
  parameter int INI_Y     = 189,
  parameter int VEL       = 2,
  parameter int BOOST     = 20,
  parameter int FRAME_DIV = 1
) (
  input  logic       pixel_clk_i,
  input  logic       reset_n_i,
  input  logic       v_sync_i,
  input  logic [3:0] dir_i,
  input  logic       boost_n_i,
  input  logic       center_req_i,
  output logic [9:0] pos_x_o,
  output logic [9:0] pos_y_o,
  output logic [3:0] at_edge_o,
  output logic       dir_err_o,
  output logic       upd_strobe_o
);

  localparam int              CW       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0]   FRM_LAST = CW'(FRAME_DIV - 1);
  localparam logic [10:0]     LIM_X    = 11'(SCREEN_W - RECT_W);
  localparam logic [10:0]     LIM_Y    = 11'(SCREEN_H - RECT_H);
  localparam logic [9:0]      INI_X_V  = 10'(INI_X);
  localparam logic [9:0]      INI_Y_V  = 10'(INI_Y);
  localparam logic [10:0]     VEL_V    = 11'(VEL);

  typedef enum logic [1:0] {IDLE, CALC_Y, CALC_X, COMMIT} state_t;

  state_t          state_q, state_d;
  logic            vs_q;
  logic [CW-1:0]   frm_cnt_q, frm_cnt_d;
  logic [3:0]      snap_q, snap_d;
  logic [9:0]      nxt_x_q, nxt_x_d, nxt_y_q, nxt_y_d;
  logic [9:0]      pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [3:0]      at_edge_q, at_edge_d;
  logic            dir_err_q, dir_err_d;
  logic            upd_strobe_q, upd_strobe_d;
  logic            ctr_pend_q, ctr_pend_d;
  logic            tick, multi;
  logic [10:0]     step;

  // Saturating move along one axis; 11-bit math so neither direction can wrap.
  function automatic logic [9:0] step_axis(input logic [9:0] cur, input logic inc,
                                           input logic dec, input logic [10:0] stp,
                                           input logic [10:0] lim);
    logic [10:0] c, r;
    c = {1'b0, cur};
    r = c;
    if (inc)      r = ((c + stp) > lim) ? lim : (c + stp);
    else if (dec) r = (c <= stp) ? 11'd0 : (c - stp);
    return 10'(r);
  endfunction

`ifdef RECT_BOOST_EN
  localparam logic [10:0] BOOST_V = 11'(BOOST);
  logic bst_s1_q, bst_s2_q, bst_s3_q;
  logic boost_pend_q, boost_pend_d;

  always_ff @(posedge pixel_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      bst_s1_q     <= 1'b1;
      bst_s2_q     <= 1'b1;
      bst_s3_q     <= 1'b1;
      boost_pend_q <= 1'b0;
    end else begin
      bst_s1_q     <= boost_n_i;
      bst_s2_q     <= bst_s1_q;
      bst_s3_q     <= bst_s2_q;
      boost_pend_q <= boost_pend_d;
    end
  end

  // A press landing in the COMMIT cycle survives for the next update.
  always_comb begin
    boost_pend_d = boost_pend_q;
    if (state_q == COMMIT) boost_pend_d = 1'b0;
    if (!bst_s2_q && bst_s3_q) boost_pend_d = 1'b1;
  end

  assign step = boost_pend_q ? BOOST_V : VEL_V;
`else
  logic unused_boost_n;
  assign unused_boost_n = boost_n_i;
  assign step           = VEL_V;
`endif

  assign tick  = !v_sync_i && vs_q;
  assign multi = !$onehot0(snap_q);

  always_comb begin
    state_d      = state_q;
    frm_cnt_d    = frm_cnt_q;
    snap_d       = snap_q;
    nxt_x_d      = nxt_x_q;
    nxt_y_d      = nxt_y_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    at_edge_d    = at_edge_q;
    dir_err_d    = dir_err_q;
    upd_strobe_d = 1'b0;
    ctr_pend_d   = ctr_pend_q | center_req_i;
    case (state_q)
      IDLE: begin
        if (tick) begin
          if (frm_cnt_q == FRM_LAST) begin
            frm_cnt_d = '0;
            snap_d    = dir_i;
            state_d   = CALC_Y;
          end else begin
            frm_cnt_d = frm_cnt_q + 1'b1;
          end
        end
      end
      CALC_Y: begin
        nxt_y_d = step_axis(pos_y_q, snap_q[0] && !multi, snap_q[2] && !multi, step, LIM_Y);
        state_d = CALC_X;
      end
      CALC_X: begin
        nxt_x_d = step_axis(pos_x_q, snap_q[1] && !multi, snap_q[3] && !multi, step, LIM_X);
        state_d = COMMIT;
      end
      COMMIT: begin
        ctr_pend_d = center_req_i;
        if (ctr_pend_q) begin
          pos_x_d   = INI_X_V;
          pos_y_d   = INI_Y_V;
          dir_err_d = 1'b0;
        end else begin
          pos_x_d   = nxt_x_q;
          pos_y_d   = nxt_y_q;
          dir_err_d = multi;
        end
        at_edge_d    = {pos_x_d == 10'd0, pos_y_d == 10'd0,
                        pos_x_d == LIM_X[9:0], pos_y_d == LIM_Y[9:0]};
        upd_strobe_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      vs_q         <= 1'b1;
      frm_cnt_q    <= '0;
      snap_q       <= 4'b0000;
      nxt_x_q      <= INI_X_V;
      nxt_y_q      <= INI_Y_V;
      pos_x_q      <= INI_X_V;
      pos_y_q      <= INI_Y_V;
      at_edge_q    <= 4'b0000;
      dir_err_q    <= 1'b0;
      upd_strobe_q <= 1'b0;
      ctr_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= v_sync_i;
      frm_cnt_q    <= frm_cnt_d;
      snap_q       <= snap_d;
      nxt_x_q      <= nxt_x_d;
      nxt_y_q      <= nxt_y_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      at_edge_q    <= at_edge_d;
      dir_err_q    <= dir_err_d;
      upd_strobe_q <= upd_strobe_d;
      ctr_pend_q   <= ctr_pend_d;
    end
  end

  assign pos_x_o      = pos_x_q;
  assign pos_y_o      = pos_y_q;
  assign at_edge_o    = at_edge_q;
  assign dir_err_o    = dir_err_q;
  assign upd_strobe_o = upd_strobe_q;

endmodule

// File: doc/rect_motion_ctrl.md
# rect_motion_ctrl

Frame-synchronous motion controller for the on-screen rectangle. It samples the direction switches and the boost key once per video frame. It computes the next rectangle position with velocity/boost stepping and screen-edge clamping, then commits it atomically so the pixel renderer never sees a half-updated position. It sits between the board inputs (SW/KEY) and the pixel-compare logic, in the `pixel_clk` domain next to `vga_controller`.

## Interface

Parameters:
- `SCREEN_W`, 640: visible width in pixels.
- `SCREEN_H`, 480: visible height in pixels.
- `RECT_W`, 100: rectangle width; must be less than `SCREEN_W`.
- `RECT_H`, 50: rectangle height; must be less than `SCREEN_H`.
- `INI_X`, 269: reset/centre X (top-left corner).
- `INI_Y`, 189: reset/centre Y.
- `VEL`, 2: normal step in pixels per update.
- `BOOST`, 20: boosted step in pixels.
- `FRAME_DIV`, 1: perform one update every `FRAME_DIV` frames; must be at least 1.

Ports:
- `pixel_clk`, in, 1: the single clock. Every output is registered on its rising edge.
- `reset_n`, in, 1: reset. Asynchronous, active-low.
- `v_sync`, in, 1: active-low vertical sync from `vga_controller`; synchronous to `pixel_clk`.
- `dir`, in, 4: move request. Bit 0 = down (+y), bit 1 = right (+x), bit 2 = up (−y), bit 3 = left (−x).
- `boost_n`, in, 1: raw active-low boost key; asynchronous.
- `center_req`, in, 1: one-cycle pulse requesting a return to (`INI_X`, `INI_Y`).
- `pos_x`, out, 10: committed top-left X.
- `pos_y`, out, 10: committed top-left Y.
- `at_edge`, out, 4: the rectangle touches the screen edge in the corresponding direction; same bit order as `dir`.
- `dir_err`, out, 1: the last update saw more than one `dir` bit set.
- `upd_strobe`, out, 1: one-cycle pulse marking that a commit occurred.

## Operation

- Frame tick: asserted in a cycle where `v_sync` = 0 and the registered previous `v_sync` = 1.
- Frame counter: 0..`FRAME_DIV`−1, advances on each tick. An update starts on a tick where the counter equals `FRAME_DIV`−1; the counter wraps to 0 on that tick.
- FSM states: IDLE, CALC_Y, CALC_X, COMMIT.
  - IDLE goes to CALC_Y on an update tick. `dir` is captured into a snapshot register in that same cycle.
  - CALC_Y goes to CALC_X, CALC_X goes to COMMIT, COMMIT goes to IDLE, each unconditionally.
  - Ticks arriving outside IDLE are ignored and do not advance the frame counter.
- `boost_n` handling: a 2-flop synchroniser, then falling-edge detection. A detected falling edge sets `boost_pend`.
- Step selection: step = `BOOST` if `boost_pend` is set, else `VEL`. `boost_pend` is cleared in COMMIT whether or not any movement occurred.
- Direction decoding:
  - Snapshot popcount = 1: move along that single axis.
  - Snapshot = 0: no move.
  - Popcount > 1: no move, and `dir_err` is set to 1 at commit. `dir_err` is cleared at the next commit with popcount ≤ 1.
- Arithmetic uses 11-bit intermediates with no wrap-around.
  - +y: next = min(pos_y + step, `SCREEN_H`−`RECT_H`).
  - −y: next = (pos_y ≤ step) ? 0 : pos_y − step.
  - X follows the same rules, using `SCREEN_W`−`RECT_W` as the limit.
  - CALC_Y computes next_y; CALC_X computes next_x. Both are held in shadow registers.
- `center_req`: any pulse sets `ctr_pend`.
  - At COMMIT, if `ctr_pend` is set, the position is loaded with `INI_X`/`INI_Y` instead of the shadow values. This overrides motion and error: `dir_err` is cleared to 0.
  - `ctr_pend` is cleared at COMMIT.
  - A `center_req` pulse arriving in the COMMIT cycle itself remains pending for the next update.
- COMMIT writes `pos_x`, `pos_y`, `at_edge` and `dir_err`, and pulses `upd_strobe`. `at_edge` is computed from the new values:
  - bit 0: y = `SCREEN_H`−`RECT_H`
  - bit 1: x = `SCREEN_W`−`RECT_W`
  - bit 2: y = 0
  - bit 3: x = 0

## Timing

- Reset values (all forced immediately and asynchronously on `reset_n` low):
  - `pos_x` = `INI_X`, `pos_y` = `INI_Y`
  - `at_edge` = 0, `dir_err` = 0, `upd_strobe` = 0
  - FSM = IDLE, frame counter = 0
  - `boost_pend` = 0, `ctr_pend` = 0, synchroniser flops = 1
- Latency:
  - Tick in cycle T gives CALC_Y in T+1, CALC_X in T+2 and COMMIT in T+3.
  - New `pos`/`at_edge`/`dir_err` values and `upd_strobe` = 1 are visible from T+4.
  - `upd_strobe` = 0 again at T+5.
- `pos_x`/`pos_y` change only at the commit edge, and both change on the same edge.
- Boost key latency: a falling edge on `boost_n` sets `boost_pend` 3 cycles later. It is therefore honoured only if it reaches the flag before the CALC_Y cycle.
- Reset asserted mid-update aborts the update. No commit occurs and no strobe is emitted.

## Configuration

- `RECT_BOOST_EN` defined: the boost synchroniser, edge detector and `boost_pend` are present, and the step is selected as described above.
- `RECT_BOOST_EN` undefined: `boost_n` is ignored, no boost logic is instantiated, and the step is always `VEL`. All other behaviour is identical.

## Test plan

- Reset, then wait with no ticks → `pos` = (269, 189), `at_edge` = 0000, `dir_err` = 0, `upd_strobe` never asserted.
- `dir` = 0001, one tick at cycle T → `pos_y` = 191 and `upd_strobe` = 1 at T+4. `pos_x` stays 269.
- `RECT_BOOST_EN` defined: `boost_n` pulse low, `dir` = 0010, then a tick → `pos_x` = 289. A second tick without a new press → 291.
- Clamp and underflow:
  - Preset `pos_y` = 428, `dir` = 0001 → 430 with `at_edge[0]` = 1; a further tick keeps 430.
  - `pos_y` = 1, `dir` = 0100 → 0 with `at_edge[2]` = 1.
- `dir` = 0011, then a tick → `pos` unchanged, `dir_err` = 1, `upd_strobe` pulses. Next tick with `dir` = 0000 → `dir_err` = 0.
- Move to (300, 200), then pulse `center_req` together with `dir` = 1000 → (269, 189) at commit. Assert `reset_n` low at T+2 of a later update → no strobe, `pos` = (269, 189).
